// File: rtl/clct_best_decoder_fifo.sv
// Decodes the registered 1-of-5 CFEB sort winner, qualifies it against a hit
// threshold, and queues accepted CLCTs in a small FIFO with saturating status counters.
module clct_best_decoder_fifo #(
  parameter int unsigned MXPATB     = 6,
  parameter int unsigned MXKEYBX    = 8,
  parameter int unsigned MXPATC     = 11,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MXCNTB     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              best_vld,
  input  logic [MXPATB-1:0] best_pat,
  input  logic [MXKEYBX-1:0] best_key,
  input  logic [MXPATC-1:0] best_carry,
  input  logic [2:0]        hit_thresh,
  input  logic              cnt_clear,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [2:0]        out_cfeb,
  output logic [4:0]        out_key,
  output logic [2:0]        out_nhit,
  output logic [2:0]        out_patid,
  output logic              out_bend,
  output logic [MXPATC-1:0] out_carry,
  output logic              fifo_full,
  output logic [MXCNTB-1:0] cnt_accept,
  output logic [MXCNTB-1:0] cnt_drop,
  output logic [MXCNTB-1:0] cnt_ovf
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTRW = AW + 1;
  localparam int unsigned EW   = 3 + 5 + MXPATB + MXPATC;

  logic              s1_vld_q,   s1_vld_d;
  logic [MXPATB-1:0] s1_pat_q,   s1_pat_d;
  logic [MXKEYBX-1:0] s1_key_q,  s1_key_d;
  logic [MXPATC-1:0] s1_carry_q, s1_carry_d;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [MXCNTB-1:0] cnt_accept_q, cnt_accept_d;
  logic [MXCNTB-1:0] cnt_drop_q,   cnt_drop_d;
  logic [MXCNTB-1:0] cnt_ovf_q,    cnt_ovf_d;

  logic [2:0]    s1_cfeb, s1_nhit;
  logic          bad_key, qual, empty, full, pop, push, ovf, drop;
  logic [EW-1:0] head;

  function automatic logic [MXCNTB-1:0] sat_inc(input logic [MXCNTB-1:0] c);
    return (&c) ? c : c + MXCNTB'(1);
  endfunction

  // Decode and qualify the stage-1 candidate; derive FIFO control from the pointers.
  always_comb begin
    s1_cfeb = s1_key_q[7:5];
    s1_nhit = s1_pat_q[5:3];
    bad_key = s1_cfeb > 3'd4;
    qual    = s1_vld_q && !bad_key && (s1_nhit >= hit_thresh);
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = !empty && out_rdy;
    push    = qual && (!full || pop);
    ovf     = qual && full && !pop;
    drop    = s1_vld_q && !qual;
  end

  always_comb begin
    s1_vld_d   = best_vld;
    s1_pat_d   = best_pat;
    s1_key_d   = best_key;
    s1_carry_d = best_carry;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {s1_cfeb, s1_key_q[4:0], s1_pat_q, s1_carry_q};
      wr_ptr_d = wr_ptr_q + PTRW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTRW'(1);
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_accept_d = push ? sat_inc(cnt_accept_q) : cnt_accept_q;
    cnt_drop_d   = drop ? sat_inc(cnt_drop_q)   : cnt_drop_q;
    cnt_ovf_d    = ovf  ? sat_inc(cnt_ovf_q)    : cnt_ovf_q;
    if (cnt_clear) begin
      cnt_accept_d = '0;
      cnt_drop_d   = '0;
      cnt_ovf_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_vld_q     <= 1'b0;
      s1_pat_q     <= '0;
      s1_key_q     <= '0;
      s1_carry_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_accept_q <= '0;
      cnt_drop_q   <= '0;
      cnt_ovf_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_pat_q     <= s1_pat_d;
      s1_key_q     <= s1_key_d;
      s1_carry_q   <= s1_carry_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_accept_q <= cnt_accept_d;
      cnt_drop_q   <= cnt_drop_d;
      cnt_ovf_q    <= cnt_ovf_d;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  // Head is read straight from storage and forced to zero while empty.
  always_comb begin
    head       = mem_q[rd_ptr_q[AW-1:0]] & {EW{!empty}};
    out_vld    = !empty;
    fifo_full  = full;
    out_cfeb   = head[EW-1 -: 3];
    out_key    = head[EW-4 -: 5];
    out_nhit   = head[MXPATC+5 -: 3];
    out_patid  = head[MXPATC+2 -: 3];
    out_bend   = head[MXPATC];
    out_carry  = head[MXPATC-1:0];
    cnt_accept = cnt_accept_q;
    cnt_drop   = cnt_drop_q;
    cnt_ovf    = cnt_ovf_q;
  end

endmodule

// File: tb/tb_clct_best_decoder_fifo.sv
// Directed self-checking bench for clct_best_decoder_fifo; counters are
// built narrow so saturation is reachable in a few hundred cycles.
module tb_clct_best_decoder_fifo;

  localparam int unsigned CNTW = 8;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            best_vld;
  logic [5:0]      best_pat;
  logic [7:0]      best_key;
  logic [10:0]     best_carry;
  logic [2:0]      hit_thresh;
  logic            cnt_clear;
  logic            out_vld;
  logic            out_rdy;
  logic [2:0]      out_cfeb;
  logic [4:0]      out_key;
  logic [2:0]      out_nhit;
  logic [2:0]      out_patid;
  logic            out_bend;
  logic [10:0]     out_carry;
  logic            fifo_full;
  logic [CNTW-1:0] cnt_accept;
  logic [CNTW-1:0] cnt_drop;
  logic [CNTW-1:0] cnt_ovf;

  int checks   = 0;
  int failures = 0;

  clct_best_decoder_fifo #(.MXCNTB(CNTW)) dut (
    .clock(clock), .reset_n(reset_n),
    .best_vld(best_vld), .best_pat(best_pat), .best_key(best_key), .best_carry(best_carry),
    .hit_thresh(hit_thresh), .cnt_clear(cnt_clear),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_cfeb(out_cfeb), .out_key(out_key), .out_nhit(out_nhit), .out_patid(out_patid),
    .out_bend(out_bend), .out_carry(out_carry), .fifo_full(fifo_full),
    .cnt_accept(cnt_accept), .cnt_drop(cnt_drop), .cnt_ovf(cnt_ovf)
  );

  always #5 clock = ~clock;

  // Vector table: pattern, key, carry and the hand-decoded head fields.
  logic [5:0]  v_pat   [6] = '{6'b011_000, 6'b100_001, 6'b101_010, 6'b110_011, 6'b111_100, 6'b011_101};
  logic [7:0]  v_key   [6] = '{8'h01, 8'h25, 8'h4A, 8'h6F, 8'h9F, 8'h80};
  logic [10:0] v_carry [6] = '{11'h001, 11'h155, 11'h2AA, 11'h7FF, 11'h400, 11'h0F0};
  logic [2:0]  e_cfeb  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
  logic [4:0]  e_lkey  [6] = '{5'd1, 5'd5, 5'd10, 5'd15, 5'd31, 5'd0};
  logic [2:0]  e_nhit  [6] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
  logic [2:0]  e_patid [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic        e_bend  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [5:0] pat, input logic [7:0] key, input logic [10:0] carry);
    best_vld   = 1'b1;
    best_pat   = pat;
    best_key   = key;
    best_carry = carry;
    tick();
  endtask

  task automatic send_vec(input int i);
    send(v_pat[i], v_key[i], v_carry[i]);
  endtask

  task automatic idle(input int n);
    best_vld = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_clear();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
  endtask

  task automatic check_head(input string tag, input int i);
    check({tag, ".vld"},   32'(out_vld),   32'd1);
    check({tag, ".cfeb"},  32'(out_cfeb),  32'(e_cfeb[i]));
    check({tag, ".key"},   32'(out_key),   32'(e_lkey[i]));
    check({tag, ".nhit"},  32'(out_nhit),  32'(e_nhit[i]));
    check({tag, ".patid"}, 32'(out_patid), 32'(e_patid[i]));
    check({tag, ".bend"},  32'(out_bend),  32'(e_bend[i]));
    check({tag, ".carry"}, 32'(out_carry), 32'(v_carry[i]));
  endtask

  initial begin
    reset_n = 1'b0; best_vld = 1'b0; best_pat = '0; best_key = '0; best_carry = '0;
    hit_thresh = 3'd3; cnt_clear = 1'b0; out_rdy = 1'b1;
    tick(); tick();
    check("rst.vld",  32'(out_vld),    32'd0);
    check("rst.full", 32'(fifo_full),  32'd0);
    check("rst.acc",  32'(cnt_accept), 32'd0);
    check("rst.drop", 32'(cnt_drop),   32'd0);
    check("rst.ovf",  32'(cnt_ovf),    32'd0);
    check("rst.data", 32'({out_cfeb, out_key, out_carry}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single candidate, two-cycle latency.
    send(6'b101_011, 8'h83, 11'h2A5);
    best_vld = 1'b0;
    check("single.lat1", 32'(out_vld), 32'd0);
    tick();
    check("single.vld",   32'(out_vld),   32'd1);
    check("single.cfeb",  32'(out_cfeb),  32'd4);
    check("single.key",   32'(out_key),   32'd3);
    check("single.nhit",  32'(out_nhit),  32'd5);
    check("single.patid", 32'(out_patid), 32'd3);
    check("single.bend",  32'(out_bend),  32'd1);
    check("single.carry", 32'(out_carry), 32'h2A5);
    check("single.acc",   32'(cnt_accept), 32'd1);
    tick();
    check("single.popped", 32'(out_vld), 32'd0);

    // Threshold drop, bad key drop, largest good key, zero threshold.
    send(6'b010_111, 8'h10, 11'h011);
    idle(1);
    check("thr.vld",  32'(out_vld),  32'd0);
    check("thr.drop", 32'(cnt_drop), 32'd1);
    send(6'b111_000, 8'hA0, 11'h022);
    idle(1);
    check("badkey.vld",  32'(out_vld),  32'd0);
    check("badkey.drop", 32'(cnt_drop), 32'd2);
    send_vec(4);
    idle(1);
    check_head("key9f", 4);
    check("key9f.acc", 32'(cnt_accept), 32'd2);
    tick();
    hit_thresh = 3'd0;
    send(6'b000_000, 8'h00, 11'h033);
    idle(1);
    check("thr0.vld",  32'(out_vld),    32'd1);
    check("thr0.nhit", 32'(out_nhit),   32'd0);
    check("thr0.acc",  32'(cnt_accept), 32'd3);
    check("thr0.drop", 32'(cnt_drop),   32'd2);
    hit_thresh = 3'd3;
    idle(1);
    pulse_clear();
    check("clr.acc",  32'(cnt_accept), 32'd0);
    check("clr.drop", 32'(cnt_drop),   32'd0);

    // Backpressure and overflow: six candidates into a four-deep queue.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_vec(i);
    check("ovf.notfull3", 32'(fifo_full), 32'd0);
    send_vec(4);
    check("ovf.full4", 32'(fifo_full), 32'd1);
    check("ovf.ovf0",  32'(cnt_ovf),   32'd0);
    send_vec(5);
    idle(1);
    check("ovf.ovf",  32'(cnt_ovf),    32'd2);
    check("ovf.acc",  32'(cnt_accept), 32'd4);
    check("ovf.hold", 32'(out_cfeb),   32'd0);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), i);
      tick();
    end
    check("drain.empty", 32'(out_vld), 32'd0);
    pulse_clear();

    // Full queue with a pop on the cycle of the fifth push.
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) send_vec(i);
    best_vld = 1'b0;
    out_rdy  = 1'b1;
    tick();
    out_rdy = 1'b0;
    check("pp.full", 32'(fifo_full),  32'd1);
    check("pp.ovf",  32'(cnt_ovf),    32'd0);
    check("pp.acc",  32'(cnt_accept), 32'd5);
    out_rdy = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_head($sformatf("pp%0d", i), i);
      tick();
    end
    check("pp.empty", 32'(out_vld), 32'd0);
    pulse_clear();

    // Accept counter saturation, then clear coincident with an accept.
    best_pat = 6'b111_001; best_key = 8'h42; best_carry = 11'h123; best_vld = 1'b1;
    for (int k = 0; k < 260; k++) tick();
    check("sat.acc", 32'(cnt_accept), 32'hFF);
    tick();
    check("sat.hold", 32'(cnt_accept), 32'hFF);
    idle(3);
    check("sat.drained", 32'(out_vld), 32'd0);
    send(6'b100_000, 8'h21, 11'h0AB);
    best_vld  = 1'b0;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    check("clracc.acc", 32'(cnt_accept), 32'd0);
    check("clracc.vld", 32'(out_vld),    32'd1);
    check("clracc.key", 32'(out_key),    32'd1);
    tick();

    // Drop counter saturation.
    hit_thresh = 3'd7;
    best_pat = 6'b011_000; best_key = 8'h05; best_vld = 1'b1;
    for (int k = 0; k < 262; k++) tick();
    check("satdrop.drop", 32'(cnt_drop), 32'hFF);
    check("satdrop.vld",  32'(out_vld),  32'd0);
    idle(2);
    hit_thresh = 3'd3;

    // Reset mid-stream with three queued entries and one in stage 1.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_vec(i);
    best_vld = 1'b0;
    check("rstm.pre", 32'(out_vld), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rstm.vld",  32'(out_vld),    32'd0);
    check("rstm.acc",  32'(cnt_accept), 32'd0);
    check("rstm.drop", 32'(cnt_drop),   32'd0);
    check("rstm.ovf",  32'(cnt_ovf),    32'd0);
    check("rstm.full", 32'(fifo_full),  32'd0);
    idle(3);
    check("rstm.stale", 32'(out_vld),    32'd0);
    check("rstm.acc2",  32'(cnt_accept), 32'd0);
    check("rstm.data",  32'({out_cfeb, out_key, out_carry}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
